// File: rtl/vend_change_dispenser_pkg.sv
// Shared vending definitions: state encoding, coin denominations and the
// default timing parameters of the change dispenser.
package vend_change_dispenser_pkg;

  localparam int CREDIT_W_DEF  = 4;
  localparam int PULSE_LEN_DEF = 4;
  localparam int TIMEOUT_DEF   = 64;
  localparam int GAP_LEN_DEF   = 8;
  localparam int MAX_RETRY_DEF = 3;

  // Coin values of the two hoppers, in credit units.
  localparam int DENOM_HI = 5;
  localparam int DENOM_LO = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_PULSE      = 3'd2,
    ST_WAIT_SENSE = 3'd3,
    ST_GAP        = 3'd4,
    ST_DONE       = 3'd5,
    ST_FAULT      = 3'd6
  } vend_state_e;

  // Value of the coin currently being paid.
  function automatic int denom_units(input logic use_hi);
    return use_hi ? DENOM_HI : DENOM_LO;
  endfunction

  // Counter width able to hold the largest reload value of the shared timer.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Bus between the vending controller / coin mechanics and the dispenser.
//
// Handshake: refund_valid/refund_amt are offered by the controller and held
// until accepted; a transfer happens on the rising clock edge where both
// refund_valid and refund_ready are high. refund_ready never depends on
// refund_valid, and refund_valid is ignored while refund_ready is low.
interface vend_change_dispenser_if #(
  parameter int CREDIT_W = 4
);
  import vend_change_dispenser_pkg::*;

  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amt;
  logic                refund_ready;
  logic                hop5_empty;
  logic                hop1_empty;
  logic                coin_sense;
  logic                pay5;
  logic                pay1;
  logic [CREDIT_W-1:0] remaining;
  logic                done;
  logic                fault;
  logic                clear_fault;
  vend_state_e         dbg_state;

  // Controller / coin-mechanics side.
  modport master (
    output refund_valid, refund_amt, hop5_empty, hop1_empty, coin_sense,
           clear_fault,
    input  refund_ready, pay5, pay1, remaining, done, fault, dbg_state
  );

  // Dispenser side.
  modport slave (
    input  refund_valid, refund_amt, hop5_empty, hop1_empty, coin_sense,
           clear_fault,
    output refund_ready, pay5, pay1, remaining, done, fault, dbg_state
  );

endinterface

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter with an expiry flag. A load sets the count; the
// counter then steps down once per cycle and parks at zero, where expired_o
// is high. Loading N-1 therefore gives a phase of exactly N cycles.
module vend_cycle_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: accepts a refund amount and pays it out through a
// 5-unit and a 1-unit hopper, confirming each coin on the drop sensor,
// retrying missed coins and latching a fault when payout cannot finish.
module vend_change_dispenser
  import vend_change_dispenser_pkg::*;
#(
  parameter int CREDIT_W  = CREDIT_W_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int GAP_LEN   = GAP_LEN_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vend_change_dispenser_if.slave bus
);

  localparam int TIMER_W = timer_width(PULSE_LEN, TIMEOUT, GAP_LEN);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_LEN - 1);
  localparam logic [CREDIT_W-1:0] HI_UNITS  = CREDIT_W'(DENOM_HI);
  localparam logic [CREDIT_W-1:0] LO_UNITS  = CREDIT_W'(DENOM_LO);
  localparam logic [RETRY_W-1:0]  RETRY_LIM = RETRY_W'(MAX_RETRY);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                denom_hi_q, denom_hi_d;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_expired;
  logic [RETRY_W-1:0]  retry_inc;

  assign retry_inc = retry_q + 1'b1;

  // One timer serves the pulse, sense-wait and inter-coin gap phases.
  vend_cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Next-state logic for the payout sequencer and its credit/retry registers.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    retry_d    = retry_q;
    denom_hi_d = denom_hi_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.refund_valid) begin
          rem_d   = bus.refund_amt;
          retry_d = '0;
          state_d = (bus.refund_amt == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Hopper flags are looked at afresh for every coin, so an emptied
        // 5-unit hopper falls back to paying in 1s.
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (rem_q >= HI_UNITS && !bus.hop5_empty) begin
          denom_hi_d = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = PULSE_LOAD;
          state_d    = ST_PULSE;
        end else if (rem_q >= LO_UNITS && !bus.hop1_empty) begin
          denom_hi_d = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = PULSE_LOAD;
          state_d    = ST_PULSE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_PULSE: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = WAIT_LOAD;
          state_d  = ST_WAIT_SENSE;
        end
      end
      ST_WAIT_SENSE: begin
        // A sense in the final wait cycle still counts as a delivered coin.
        if (bus.coin_sense) begin
          rem_d    = rem_q - CREDIT_W'(denom_units(denom_hi_q));
          retry_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end else if (tmr_expired) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_LIM) begin
            state_d = ST_FAULT;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
            state_d  = ST_PULSE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        // Unpaid credit stays visible until the fault is acknowledged.
        if (bus.clear_fault) begin
          rem_d   = '0;
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, credit and retry registers; reset aborts any payout in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      retry_q    <= '0;
      denom_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      retry_q    <= retry_d;
      denom_hi_q <= denom_hi_d;
    end
  end

  // Outputs decode the state register only, so reset drops them at once.
  assign bus.refund_ready = (state_q == ST_IDLE);
  assign bus.pay5         = (state_q == ST_PULSE) &&  denom_hi_q;
  assign bus.pay1         = (state_q == ST_PULSE) && !denom_hi_q;
  assign bus.remaining    = rem_q;
  assign bus.done         = (state_q == ST_DONE);
  assign bus.fault        = (state_q == ST_FAULT);
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: a sequential payout model predicts every
// output each cycle, directed scenarios pin the model with literal values,
// then randomized refunds with random hopper/sensor behaviour follow.
module tb_vend_change_dispenser;
  import vend_change_dispenser_pkg::*;

  localparam int PULSE_LEN = 4;
  localparam int TIMEOUT   = 64;
  localparam int GAP_LEN   = 8;
  localparam int MAX_RETRY = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vend_change_dispenser_if #(.CREDIT_W(4)) bus ();

  vend_change_dispenser dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- stimulus configuration ----------------
  int hop_cfg     = 0;   // 0 both full, 1 5-hopper empty, 2 both empty, 3 random
  int sense_mode  = 1;   // 0 never, 1 fixed delay, 2 random
  int sense_delay = 2;
  int spur_req    = 0;

  // Coin mechanics: hopper flags and drop sensor, all changed on negedge.
  initial begin
    int sense_cnt;
    int spur_done;
    bit prev_pay;
    sense_cnt = -1;
    spur_done = 0;
    prev_pay  = 1'b0;
    bus.coin_sense = 1'b0;
    bus.hop5_empty = 1'b0;
    bus.hop1_empty = 1'b0;
    forever begin
      @(negedge clk);
      bus.coin_sense = 1'b0;
      case (hop_cfg)
        0: begin bus.hop5_empty = 1'b0; bus.hop1_empty = 1'b0; end
        1: begin bus.hop5_empty = 1'b1; bus.hop1_empty = 1'b0; end
        2: begin bus.hop5_empty = 1'b1; bus.hop1_empty = 1'b1; end
        default: begin
          bus.hop5_empty = ($urandom_range(0, 3) == 0);
          bus.hop1_empty = ($urandom_range(0, 19) == 0);
        end
      endcase
      if (reset_n !== 1'b1) begin
        sense_cnt = -1;
      end else if (prev_pay && !(bus.pay5 || bus.pay1)) begin
        if (sense_mode == 1)      sense_cnt = sense_delay;
        else if (sense_mode == 2) sense_cnt = $urandom_range(0, TIMEOUT + 15);
        else                      sense_cnt = -1;
      end
      if (sense_cnt == 0) bus.coin_sense = 1'b1;
      if (sense_cnt >= 0) sense_cnt--;
      if (sense_cnt < 0 && spur_req != spur_done) begin
        bus.coin_sense = 1'b1;
        spur_done++;
      end else if (sense_cnt < 0 && sense_mode == 2 && $urandom_range(0, 49) == 0) begin
        bus.coin_sense = 1'b1;
      end
      prev_pay = bus.pay5 || bus.pay1;
    end
  end

  // ---------------- behavioural payout model ----------------
  bit exp_p5, exp_p1, exp_done, exp_ready, exp_fault;
  int exp_rem;
  bit m_abort;

  task automatic show(input bit p5, input bit p1, input bit dn, input bit rdy,
                      input bit flt, input int rem);
    exp_p5 = p5; exp_p1 = p1; exp_done = dn; exp_ready = rdy;
    exp_fault = flt; exp_rem = rem;
  endtask

  task automatic mt();
    @(posedge clk);
    if (reset_n !== 1'b1) m_abort = 1'b1;
  endtask

  // Fault holds the unpaid credit until clear_fault is seen on an edge.
  task automatic m_fault(input int rem);
    show(0, 0, 0, 0, 1, rem);
    do begin
      mt();
      if (m_abort) return;
    end while (bus.clear_fault !== 1'b1);
  endtask

  // One complete refund: wait for the handshake, pay coin by coin, finish.
  task automatic m_payout();
    int rem;
    int denom;
    int tries;
    bit sensed;
    show(0, 0, 0, 1, 0, 0);
    do begin
      mt();
      if (m_abort) return;
    end while (bus.refund_valid !== 1'b1);
    rem = int'(bus.refund_amt);
    if (rem != 0) begin
      forever begin
        show(0, 0, 0, 0, 0, rem);
        mt();
        if (m_abort) return;
        if (rem == 0) break;
        if (rem >= 5 && bus.hop5_empty !== 1'b1)      denom = 5;
        else if (bus.hop1_empty !== 1'b1)             denom = 1;
        else begin
          m_fault(rem);
          return;
        end
        tries  = 0;
        sensed = 1'b0;
        while (!sensed) begin
          show(denom == 5, denom == 1, 0, 0, 0, rem);
          repeat (PULSE_LEN) begin
            mt();
            if (m_abort) return;
          end
          show(0, 0, 0, 0, 0, rem);
          for (int i = 0; i < TIMEOUT; i++) begin
            mt();
            if (m_abort) return;
            if (bus.coin_sense === 1'b1) begin
              sensed = 1'b1;
              break;
            end
          end
          if (!sensed) begin
            tries++;
            if (tries == MAX_RETRY) begin
              m_fault(rem);
              return;
            end
          end
        end
        rem = rem - denom;
        show(0, 0, 0, 0, 0, rem);
        repeat (GAP_LEN) begin
          mt();
          if (m_abort) return;
        end
      end
    end
    show(0, 0, 1, 0, 0, 0);
    mt();
  endtask

  initial begin
    show(0, 0, 0, 1, 0, 0);
    forever begin
      m_abort = 1'b0;
      wait (reset_n === 1'b1);
      while (!m_abort) m_payout();
      show(0, 0, 0, 1, 0, 0);
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        chk("rst_pay5", 32'(bus.pay5), 0);
        chk("rst_pay1", 32'(bus.pay1), 0);
        chk("rst_remaining", 32'(bus.remaining), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_ready", 32'(bus.refund_ready), 1);
      end else begin
        chk("pay5", 32'(bus.pay5), 32'(exp_p5));
        chk("pay1", 32'(bus.pay1), 32'(exp_p1));
        chk("remaining", 32'(bus.remaining), 32'(exp_rem));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("fault", 32'(bus.fault), 32'(exp_fault));
        chk("refund_ready", 32'(bus.refund_ready), 32'(exp_ready));
      end
    end
  end

  // ---------------- observation monitor ----------------
  int cyc = 0;
  int p5_rises = 0, p1_rises = 0, done_cnt = 0, bad_w1 = 0, both_high = 0;
  int rise_q[$];
  int rem_log[$];

  initial begin
    bit pp5, pp1;
    int w1;
    int last_rem;
    pp5 = 0; pp1 = 0; w1 = 0; last_rem = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.pay5 === 1'b1 && !pp5) begin p5_rises++; rise_q.push_back(cyc); end
      if (bus.pay1 === 1'b1 && !pp1) begin p1_rises++; rise_q.push_back(cyc); end
      if (bus.pay1 === 1'b1) w1++;
      else begin
        if (pp1 && w1 != PULSE_LEN) bad_w1++;
        w1 = 0;
      end
      if (bus.pay5 === 1'b1 && bus.pay1 === 1'b1) both_high++;
      if (bus.done === 1'b1) done_cnt++;
      if (int'(bus.remaining) != last_rem) begin
        last_rem = int'(bus.remaining);
        rem_log.push_back(last_rem);
      end
      pp5 = (bus.pay5 === 1'b1);
      pp1 = (bus.pay1 === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic refund(input int amt);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.refund_valid = 1'b1;
    bus.refund_amt   = 4'(amt);
    for (int i = 0; i < 300; i++) begin
      if (bus.refund_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.refund_valid = 1'b0;
    #1;
    chk("handshake_taken", 32'(ok), 1);
  endtask

  task automatic wait_quiet(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (bus.refund_ready === 1'b1 || bus.fault === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("payout_settled", 32'(ok), 1);
  endtask

  task automatic clear_fault_pulse();
    @(negedge clk);
    bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.clear_fault = 1'b0;
    #1;
    chk("clr_ready", 32'(bus.refund_ready), 1);
    chk("clr_fault", 32'(bus.fault), 0);
    chk("clr_remaining", 32'(bus.remaining), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation budget exhausted (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b5, b1, bd, br, bw, n;
    bit reached;
    reset_n          = 1'b1;
    bus.refund_valid = 1'b0;
    bus.refund_amt   = '0;
    bus.clear_fault  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_ready", 32'(bus.refund_ready), 1);
    chk("reset_remaining", 32'(bus.remaining), 0);

    // Amount 7, both hoppers full, sense 2 cycles after each pulse.
    hop_cfg = 0; sense_mode = 1; sense_delay = 2;
    b5 = p5_rises; b1 = p1_rises; bd = done_cnt; br = rem_log.size();
    refund(7);
    wait_quiet(2000);
    chk("t7_pay5_pulses", 32'(p5_rises - b5), 1);
    chk("t7_pay1_pulses", 32'(p1_rises - b1), 2);
    chk("t7_done_pulses", 32'(done_cnt - bd), 1);
    chk("t7_ready_back", 32'(bus.refund_ready), 1);
    chk("t7_rem_steps", 32'(rem_log.size() - br), 4);
    if (rem_log.size() - br == 4) begin
      chk("t7_rem_a", 32'(rem_log[br]), 7);
      chk("t7_rem_b", 32'(rem_log[br + 1]), 2);
      chk("t7_rem_c", 32'(rem_log[br + 2]), 1);
      chk("t7_rem_d", 32'(rem_log[br + 3]), 0);
    end

    // Amount 6 with the 5-unit hopper empty: six 4-cycle pay1 pulses.
    hop_cfg = 1;
    b5 = p5_rises; b1 = p1_rises; bd = done_cnt; bw = bad_w1;
    refund(6);
    wait_quiet(2000);
    chk("t6_pay1_pulses", 32'(p1_rises - b1), 6);
    chk("t6_pay5_pulses", 32'(p5_rises - b5), 0);
    chk("t6_pulse_width", 32'(bad_w1 - bw), 0);
    chk("t6_done_pulses", 32'(done_cnt - bd), 1);

    // Amount 3, sensor never fires: three retries spaced by the timeout.
    hop_cfg = 0; sense_mode = 0;
    b1 = p1_rises;
    refund(3);
    wait_quiet(2000);
    chk("t3_fault", 32'(bus.fault), 1);
    chk("t3_remaining", 32'(bus.remaining), 3);
    chk("t3_pay1_pulses", 32'(p1_rises - b1), 3);
    n = rise_q.size();
    if (n >= 3) begin
      chk("t3_spacing_a", 32'(rise_q[n - 1] - rise_q[n - 2]), 68);
      chk("t3_spacing_b", 32'(rise_q[n - 2] - rise_q[n - 3]), 68);
    end
    clear_fault_pulse();

    // Amount 4, both hoppers empty: fault with no pulse, valid ignored.
    hop_cfg = 2; sense_mode = 1;
    b5 = p5_rises; b1 = p1_rises;
    refund(4);
    wait_quiet(200);
    chk("t4_fault", 32'(bus.fault), 1);
    chk("t4_remaining", 32'(bus.remaining), 4);
    chk("t4_no_pulse", 32'((p1_rises - b1) + (p5_rises - b5)), 0);
    @(negedge clk);
    bus.refund_valid = 1'b1;
    bus.refund_amt   = 4'd9;
    repeat (3) @(negedge clk);
    bus.refund_valid = 1'b0;
    #1;
    chk("t4_valid_ignored_rem", 32'(bus.remaining), 4);
    chk("t4_valid_ignored_flt", 32'(bus.fault), 1);
    hop_cfg = 0;
    clear_fault_pulse();

    // Amount 0: done immediately after the handshake; spurious sense in IDLE.
    b5 = p5_rises; b1 = p1_rises; bd = done_cnt;
    refund(0);
    chk("t0_done_next_cycle", 32'(bus.done), 1);
    wait_quiet(50);
    chk("t0_no_pulse", 32'((p1_rises - b1) + (p5_rises - b5)), 0);
    chk("t0_done_pulses", 32'(done_cnt - bd), 1);
    spur_req++;
    repeat (4) @(negedge clk);
    #1;
    chk("spurious_rem", 32'(bus.remaining), 0);
    chk("spurious_ready", 32'(bus.refund_ready), 1);

    // Reset during the second pay1 pulse of amount 5 (5-unit hopper empty).
    hop_cfg = 1; sense_mode = 1; sense_delay = 2;
    b1 = p1_rises;
    refund(5);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (p1_rises - b1 == 2) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached", 32'(reached), 1);
    chk("rst_mid_pay1_before", 32'(bus.pay1), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_pay1_drop", 32'(bus.pay1), 0);
    chk("rst_mid_remaining", 32'(bus.remaining), 0);
    chk("rst_mid_ready", 32'(bus.refund_ready), 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    hop_cfg = 0;
    b1 = p1_rises; bd = done_cnt;
    refund(1);
    wait_quiet(500);
    chk("post_rst_pay1_pulses", 32'(p1_rises - b1), 1);
    chk("post_rst_done", 32'(done_cnt - bd), 1);
    chk("post_rst_remaining", 32'(bus.remaining), 0);

    // Randomized refunds with random hopper flags and sensor timing.
    hop_cfg = 3; sense_mode = 2;
    for (int k = 0; k < 30; k++) begin
      refund($urandom_range(0, 15));
      wait_quiet(6000);
      if (bus.fault === 1'b1) clear_fault_pulse();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    hop_cfg = 0; sense_mode = 1;
    repeat (4) @(negedge clk);
    #1;
    chk("never_both_pay", 32'(both_high), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
